// File: rtl/pimt1_collect.sv
`default_nettype none
// ============================================================================
// Module   : pimt1_collect
// Purpose  : Output-side collector for the pimt_1 multiply stage. Buffers every
//            product in a FIFO, tags it with its position in the frame, and
//            presents it on a valid/ready stream with last flag, frame-done
//            pulse and sticky overflow detection.
// Ports    : clk, rst_n (async, active-low)
//            pimt1_result / pimt1_result_vld : unstallable product input
//            clr                             : sync flush of FIFO/index/overflow
//            out_data/out_idx/out_last/out_vld, out_rdy : output stream
//            fifo_level                      : occupied entries, 0..DEPTH
//            overflow                        : sticky, sample hit a full FIFO
//            frame_done                      : pulse after last word transfers
// Revision : 1.0 - initial release
// ============================================================================
module pimt1_collect #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = $clog2(FRAME_LEN)  // derived, keep default
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pimt1_result,
  input  logic                     pimt1_result_vld,
  input  logic                     clr,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + DATA_W;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0] c_FULL     = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] c_ONE      = LVL_W'(1);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] r_in_idx;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [LVL_W-1:0] w_level_nxt;
  logic [LVL_W-1:0] w_stored;
  logic [PTR_W-1:0] w_rd_sel;
  logic [ENT_W-1:0] w_head;
  logic [IDX_W-1:0] w_idx_nxt;

  // fifo_level counts every word not yet transferred, including the one
  // currently sitting in the output registers.
  assign w_full = (fifo_level == c_FULL);
  assign w_pop  = out_vld & out_rdy;
  assign w_push = pimt1_result_vld & (~w_full | w_pop);
  assign w_drop = pimt1_result_vld & w_full & ~w_pop;

  assign w_idx_nxt = (r_in_idx == c_LAST_IDX) ? '0 : r_in_idx + IDX_W'(1);

  always_comb begin
    w_level_nxt = fifo_level;
    if (w_push && !w_pop)
      w_level_nxt = fifo_level + c_ONE;
    else if (w_pop && !w_push)
      w_level_nxt = fifo_level - c_ONE;
  end

  // Words already in memory once this edge's pop is accounted for. If none
  // remain, the head after the edge is the word being pushed right now, which
  // is bypassed straight into the output registers (first-word-fall-through).
  assign w_stored = fifo_level - (w_pop ? c_ONE : '0);
  assign w_rd_sel = r_rd_ptr + (w_pop ? PTR_W'(1) : '0);
  assign w_head   = (w_stored != '0) ? r_mem[w_rd_sel] : {r_in_idx, pimt1_result};

  // Storage array carries no reset; validity is tracked by the pointers/level.
  // When full with a simultaneous pop, wr_ptr equals rd_ptr, and the entry
  // overwritten is the one leaving, while the head is read from rd_ptr+1.
  always_ff @(posedge clk) begin
    if (w_push && !clr)
      r_mem[r_wr_ptr] <= {r_in_idx, pimt1_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_idx   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else if (clr) begin
      // Same-cycle flush; a concurrent input sample is discarded.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_idx   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      out_vld    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Index advances even on a drop so frame alignment survives overflow.
      if (pimt1_result_vld)
        r_in_idx <= w_idx_nxt;
      fifo_level <= w_level_nxt;
      overflow   <= overflow | w_drop;
      frame_done <= w_pop & out_last;
      out_vld    <= (w_level_nxt != '0);
      // Output words are held when the FIFO drains empty.
      if (w_level_nxt != '0) begin
        out_data <= w_head[DATA_W-1:0];
        out_idx  <= w_head[ENT_W-1:DATA_W];
        out_last <= (w_head[ENT_W-1:DATA_W] == c_LAST_IDX);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pimt1_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_pimt1_collect
// Purpose  : Directed self-checking bench for pimt1_collect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pimt1_collect;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int FLEN   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] pimt1_result;
  logic              pimt1_result_vld;
  logic              clr;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              out_vld;
  logic              out_rdy;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic              frame_done;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_w;

  always #5 clk = ~clk;

  pimt1_collect #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pimt1_result     (pimt1_result),
    .pimt1_result_vld (pimt1_result_vld),
    .clr              (clr),
    .out_data         (out_data),
    .out_idx          (out_idx),
    .out_last         (out_last),
    .out_vld          (out_vld),
    .out_rdy          (out_rdy),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .frame_done       (frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pimt1_result = '0; pimt1_result_vld = 1'b0; clr = 1'b0; out_rdy = 1'b0;

    // 1 reset
    repeat (3) tick();
    chk("rst_vld",   64'(out_vld), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_fd",    64'(frame_done), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // 2 latency / streaming, one word per cycle through a 1-deep occupancy
    out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pimt1_result = 64'h3FF0_0000_0000_0000 + 64'(k);
      pimt1_result_vld = 1'b1;
      tick();
      chk("s2_vld",   64'(out_vld), 64'd1);
      chk("s2_data",  out_data, 64'h3FF0_0000_0000_0000 + 64'(k));
      chk("s2_idx",   64'(out_idx), 64'(k));
      chk("s2_last",  64'(out_last), (k == 7) ? 64'd1 : 64'd0);
      chk("s2_level", 64'(fifo_level), 64'd1);
      chk("s2_fd",    64'(frame_done), 64'd0);
    end
    pimt1_result_vld = 1'b0;
    tick();
    chk("s2_end_vld", 64'(out_vld), 64'd0);
    chk("s2_end_fd",  64'(frame_done), 64'd1);
    chk("s2_end_lvl", 64'(fifo_level), 64'd0);
    tick();
    chk("s2_fd_pulse", 64'(frame_done), 64'd0);

    // 3 backpressure, fill, overflow, drain
    out_rdy = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pimt1_result = 64'h4000_0000_0000_0000 + 64'(k);
      pimt1_result_vld = 1'b1;
      tick();
      chk("s3_hold", out_data, 64'h4000_0000_0000_0000);
    end
    chk("s3_level", 64'(fifo_level), 64'd16);
    chk("s3_ovf0",  64'(overflow), 64'd0);
    pimt1_result = 64'hDEAD_BEEF_0000_0000;
    tick();
    chk("s3_ovf1",   64'(overflow), 64'd1);
    chk("s3_level2", 64'(fifo_level), 64'd16);
    pimt1_result_vld = 1'b0;
    out_rdy = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("s3_dvld", 64'(out_vld), 64'd1);
      chk("s3_ddata", out_data, 64'h4000_0000_0000_0000 + 64'(j));
      chk("s3_didx", 64'(out_idx), 64'(j % 8));
      chk("s3_dfd", 64'(frame_done), (j == 8) ? 64'd1 : 64'd0);
      tick();
    end
    chk("s3_empty", 64'(out_vld), 64'd0);
    chk("s3_fd_end", 64'(frame_done), 64'd1);
    chk("s3_ovf_sticky", 64'(overflow), 64'd1);

    // 5 clr with level 5 and overflow set; dropped position is skipped (idx 1 next)
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pimt1_result = 64'h5000_0000_0000_0000 + 64'(k);
      pimt1_result_vld = 1'b1;
      tick();
    end
    chk("s5_level", 64'(fifo_level), 64'd5);
    chk("s5_skip_idx", 64'(out_idx), 64'd1);
    clr = 1'b1;
    pimt1_result = 64'h5555_0000_0000_0000;
    tick();
    clr = 1'b0;
    pimt1_result_vld = 1'b0;
    chk("s5_clr_lvl", 64'(fifo_level), 64'd0);
    chk("s5_clr_vld", 64'(out_vld), 64'd0);
    chk("s5_clr_ovf", 64'(overflow), 64'd0);
    chk("s5_clr_fd",  64'(frame_done), 64'd0);
    tick();

    // 4 full with simultaneous push+pop (first word doubles as post-clr idx check)
    sb.delete();
    for (int k = 0; k < 16; k++) begin
      pimt1_result = 64'h6000_0000_0000_0000 + 64'(k);
      pimt1_result_vld = 1'b1;
      sb.push_back(pimt1_result);
      tick();
      if (k == 0) begin
        chk("s5_new_idx", 64'(out_idx), 64'd0);
        chk("s5_new_vld", 64'(out_vld), 64'd1);
      end
    end
    chk("s4_full", 64'(fifo_level), 64'd16);
    out_rdy = 1'b1;
    pimt1_result = 64'h6666_0000_0000_00FF;
    void'(sb.pop_front());
    sb.push_back(pimt1_result);
    tick();
    pimt1_result_vld = 1'b0;
    chk("s4_level", 64'(fifo_level), 64'd16);
    chk("s4_ovf",   64'(overflow), 64'd0);
    for (int j = 0; j < 16; j++) begin
      exp_w = sb.pop_front();
      chk("s4_drain", out_data, exp_w);
      tick();
    end
    chk("s4_empty", 64'(out_vld), 64'd0);
    chk("s4_lvl0",  64'(fifo_level), 64'd0);

    // 6 async reset mid-frame: 3 pushed, 1 popped
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pimt1_result = 64'h7000_0000_0000_0000 + 64'(k);
      pimt1_result_vld = 1'b1;
      tick();
    end
    pimt1_result_vld = 1'b0;
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("s6_pre_lvl", 64'(fifo_level), 64'd2);
    chk("s6_pre_idx", 64'(out_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_vld",  64'(out_vld), 64'd0);
    chk("s6_rst_lvl",  64'(fifo_level), 64'd0);
    chk("s6_rst_data", out_data, 64'd0);
    chk("s6_rst_idx",  64'(out_idx), 64'd0);
    #12 rst_n = 1'b1;
    tick();
    pimt1_result = 64'h7777_0000_0000_0001;
    pimt1_result_vld = 1'b1;
    tick();
    pimt1_result_vld = 1'b0;
    chk("s6_new_vld",  64'(out_vld), 64'd1);
    chk("s6_new_idx",  64'(out_idx), 64'd0);
    chk("s6_new_data", out_data, 64'h7777_0000_0000_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
